// File: rtl/scan_tester_pkg.sv
// Shared types and width helpers for the scan chain test engine.
package scan_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_REPORT
  } scan_state_t;

  // Mismatch counter width: must hold NUM_CHAINS*CHAIN_LEN inclusive.
  function automatic int unsigned cnt_width(input int unsigned chains, input int unsigned len);
    return $clog2(chains * len + 1);
  endfunction

  // Shift index width (CHAIN_LEN >= 2, floor of 1 for safety).
  function automatic int unsigned idx_width(input int unsigned len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

  // Chain index width, at least one bit even for a single chain.
  function automatic int unsigned chain_width(input int unsigned chains);
    return (chains < 2) ? 1 : $clog2(chains);
  endfunction

endpackage

// File: rtl/scan_popcount.sv
// Combinational population count of the per-chain mismatch vector.
module scan_popcount #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] cnt
);

  // Sum of set bits.
  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/scan_chain_tester.sv
// Multi-chain scan test engine: loads a pattern MSB-first into every chain,
// compares the simultaneous unload against a masked expected response and
// reports pass/fail with mismatch statistics.
module scan_chain_tester
  import scan_tester_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 8,
  parameter int unsigned NUM_CHAINS = 1,
  parameter int unsigned CNT_W      = cnt_width(NUM_CHAINS, CHAIN_LEN)
) (
  input  logic                                  sclk,
  input  logic                                  rst_n,
  input  logic                                  pat_valid,
  output logic                                  pat_ready,
  input  logic [NUM_CHAINS*CHAIN_LEN-1:0]       pat_stim,
  input  logic [NUM_CHAINS*CHAIN_LEN-1:0]       pat_exp,
  input  logic [NUM_CHAINS*CHAIN_LEN-1:0]       pat_mask,
  input  logic                                  pat_capture,
  output logic                                  scan_en,
  output logic [NUM_CHAINS-1:0]                 scan_in,
  input  logic [NUM_CHAINS-1:0]                 scan_out,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic                                  res_fail,
  output logic [CNT_W-1:0]                      res_err_cnt,
  output logic [idx_width(CHAIN_LEN)-1:0]       res_first_idx,
  output logic [chain_width(NUM_CHAINS)-1:0]    res_first_chain,
  output logic                                  busy
);

  localparam int unsigned TOTAL  = NUM_CHAINS * CHAIN_LEN;
  localparam int unsigned IDX_W  = idx_width(CHAIN_LEN);
  localparam int unsigned CH_W   = chain_width(NUM_CHAINS);
  localparam int unsigned POP_W  = $clog2(NUM_CHAINS + 1);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(CHAIN_LEN - 1);

  scan_state_t       state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [TOTAL-1:0]  stim_q, stim_d;
  logic [TOTAL-1:0]  exp_q, exp_d;
  logic [TOTAL-1:0]  mask_q, mask_d;
  logic              cap_q, cap_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]  first_idx_q, first_idx_d;
  logic [CH_W-1:0]   first_chain_q, first_chain_d;
  logic              found_q, found_d;

  logic              scan_en_q, scan_en_d;
  logic [NUM_CHAINS-1:0] scan_in_q, scan_in_d;
  logic              res_valid_q, res_valid_d;
  logic              res_fail_q, res_fail_d;
  logic [CNT_W-1:0]  res_err_cnt_q, res_err_cnt_d;
  logic [IDX_W-1:0]  res_first_idx_q, res_first_idx_d;
  logic [CH_W-1:0]   res_first_chain_q, res_first_chain_d;
  logic              busy_q, busy_d;

  logic [NUM_CHAINS-1:0] mismatch;
  logic [POP_W-1:0]      pop_cnt;
  logic [CH_W-1:0]       hit_chain;
  logic                  hit_any;
  logic                  load_res;

  // The latched stim/exp/mask registers shift left per chain each SHIFT
  // cycle, so the current bit of every chain always sits at its slice MSB.
  // Per-chain mismatch at the current shift position and lowest failing chain.
  always_comb begin
    mismatch  = '0;
    hit_chain = '0;
    hit_any   = 1'b0;
    for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
      mismatch[c] = mask_q[c*CHAIN_LEN + CHAIN_LEN - 1] &
                    (scan_out[c] ^ exp_q[c*CHAIN_LEN + CHAIN_LEN - 1]);
      if (mismatch[c] && !hit_any) begin
        hit_chain = CH_W'(c);
        hit_any   = 1'b1;
      end
    end
  end

  scan_popcount #(
    .WIDTH (NUM_CHAINS),
    .CNT_W (POP_W)
  ) u_popcount (
    .vec (mismatch),
    .cnt (pop_cnt)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    stim_d            = stim_q;
    exp_d             = exp_q;
    mask_d            = mask_q;
    cap_d             = cap_q;
    err_cnt_d         = err_cnt_q;
    first_idx_d       = first_idx_q;
    first_chain_d     = first_chain_q;
    found_d           = found_q;
    scan_en_d         = 1'b0;
    scan_in_d         = '0;
    res_valid_d       = res_valid_q;
    res_fail_d        = res_fail_q;
    res_err_cnt_d     = res_err_cnt_q;
    res_first_idx_d   = res_first_idx_q;
    res_first_chain_d = res_first_chain_q;
    load_res          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pat_valid) begin
          stim_d        = pat_stim;
          exp_d         = pat_exp;
          mask_d        = pat_mask;
          cap_d         = pat_capture;
          err_cnt_d     = '0;
          first_idx_d   = '0;
          first_chain_d = '0;
          found_d       = 1'b0;
          k_d           = '0;
          scan_en_d     = 1'b1;
          for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
            scan_in_d[c] = pat_stim[c*CHAIN_LEN + CHAIN_LEN - 1];
          end
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        err_cnt_d = err_cnt_q + CNT_W'(pop_cnt);
        if (!found_q && hit_any) begin
          found_d       = 1'b1;
          first_idx_d   = k_q;
          first_chain_d = hit_chain;
        end
        for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
          stim_d[c*CHAIN_LEN +: CHAIN_LEN] = {stim_q[c*CHAIN_LEN +: CHAIN_LEN-1], 1'b0};
          exp_d[c*CHAIN_LEN +: CHAIN_LEN]  = {exp_q[c*CHAIN_LEN +: CHAIN_LEN-1], 1'b0};
          mask_d[c*CHAIN_LEN +: CHAIN_LEN] = {mask_q[c*CHAIN_LEN +: CHAIN_LEN-1], 1'b0};
        end
        if (k_q == LAST_K) begin
          if (cap_q) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d  = ST_REPORT;
            load_res = 1'b1;
          end
        end else begin
          k_d       = k_q + IDX_W'(1);
          scan_en_d = 1'b1;
          for (int unsigned c = 0; c < NUM_CHAINS; c++) begin
            scan_in_d[c] = stim_q[c*CHAIN_LEN + CHAIN_LEN - 2];
          end
        end
      end
      ST_CAPTURE: begin
        state_d  = ST_REPORT;
        load_res = 1'b1;
      end
      ST_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_res) begin
      res_valid_d       = 1'b1;
      res_fail_d        = (err_cnt_d != '0);
      res_err_cnt_d     = err_cnt_d;
      res_first_idx_d   = first_idx_d;
      res_first_chain_d = first_chain_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any pattern in flight.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      k_q               <= '0;
      stim_q            <= '0;
      exp_q             <= '0;
      mask_q            <= '0;
      cap_q             <= 1'b0;
      err_cnt_q         <= '0;
      first_idx_q       <= '0;
      first_chain_q     <= '0;
      found_q           <= 1'b0;
      scan_en_q         <= 1'b0;
      scan_in_q         <= '0;
      res_valid_q       <= 1'b0;
      res_fail_q        <= 1'b0;
      res_err_cnt_q     <= '0;
      res_first_idx_q   <= '0;
      res_first_chain_q <= '0;
      busy_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      k_q               <= k_d;
      stim_q            <= stim_d;
      exp_q             <= exp_d;
      mask_q            <= mask_d;
      cap_q             <= cap_d;
      err_cnt_q         <= err_cnt_d;
      first_idx_q       <= first_idx_d;
      first_chain_q     <= first_chain_d;
      found_q           <= found_d;
      scan_en_q         <= scan_en_d;
      scan_in_q         <= scan_in_d;
      res_valid_q       <= res_valid_d;
      res_fail_q        <= res_fail_d;
      res_err_cnt_q     <= res_err_cnt_d;
      res_first_idx_q   <= res_first_idx_d;
      res_first_chain_q <= res_first_chain_d;
      busy_q            <= busy_d;
    end
  end

  assign pat_ready       = (state_q == ST_IDLE);
  assign scan_en         = scan_en_q;
  assign scan_in         = scan_in_q;
  assign res_valid       = res_valid_q;
  assign res_fail        = res_fail_q;
  assign res_err_cnt     = res_err_cnt_q;
  assign res_first_idx   = res_first_idx_q;
  assign res_first_chain = res_first_chain_q;
  assign busy            = busy_q;

endmodule
